mux3ne1_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares the 16-bit 3-to-1 result mux (mux3ne1) between three requesters.

---
 rtl/mux3ne1_arbiter_pkg.sv | 35 +++
 rtl/mux3ne1_arbiter_mux3ne1.sv | 26 ++
 rtl/mux3ne1_arbiter.sv | 118 +++++++++++
 tb/tb_mux3ne1_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux3ne1_arbiter_pkg.sv
// Shared definitions for the mux3ne1 round-robin arbiter:
//   - select codes driven on S (one per requester)
//   - FSM state encoding
//   - requester count and the round-robin pick helper
package mux3ne1_arbiter_pkg;

    localparam int NREQ = 3;

    localparam logic [2:0] SEL_H0 = 3'b000;
    localparam logic [2:0] SEL_H1 = 3'b001;
    localparam logic [2:0] SEL_H2 = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // First requester strictly after 'last' in the cyclic order 0->1->2->0.
    // Returns 'last' when nothing is requesting (caller qualifies with |req).
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        idx     = last;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (req[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux3ne1_arbiter_mux3ne1.sv
// mux3ne1: 16-bit (parameterized) 3-to-1 result mux shared by the arbiter.
// Ports:
//   Hyrja0..2  in  WIDTH  candidate data
//   S          in  3      select code (SEL_H0/H1/H2); any other code falls back to Hyrja0
//   y          out WIDTH  selected data
module mux3ne1
    import mux3ne1_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] Hyrja0,
    input  logic [WIDTH-1:0] Hyrja1,
    input  logic [WIDTH-1:0] Hyrja2,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (S)
            SEL_H1:  y = Hyrja1;
            SEL_H2:  y = Hyrja2;
            default: y = Hyrja0;
        endcase
    end

endmodule

// File: rtl/mux3ne1_arbiter.sv
// mux3ne1_arbiter: round-robin sequencer sharing one mux3ne1 between three
// requesters. A grant lasts for a burst; each accepted beat is registered into
// Dalja and handed downstream with a DaljaValid/Gati handshake.
// Ports:
//   Clock, Resetn        clock / async active-low reset
//   Kerkesa[2:0]         level request per requester
//   Fundi[2:0]           last-beat flag, sampled with the accepted beat
//   Hyrja0..2            requester data
//   Pranim[2:0]          one-hot beat accept to the owner (combinational)
//   S[2:0]               mux select, also the owner identity while BUSY
//   Dalja, DaljaValid    registered output beat and its valid flag
//   Gati                 downstream ready
//   Zene                 grant active (BUSY)
module mux3ne1_arbiter
    import mux3ne1_arbiter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [2:0]       Kerkesa,
    input  logic [2:0]       Fundi,
    input  logic [WIDTH-1:0] Hyrja0,
    input  logic [WIDTH-1:0] Hyrja1,
    input  logic [WIDTH-1:0] Hyrja2,
    output logic [2:0]       Pranim,
    output logic [2:0]       S,
    output logic [WIDTH-1:0] Dalja,
    output logic             DaljaValid,
    input  logic             Gati,
    output logic             Zene
);

    localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

    state_t          state_q, state_d;
    logic [1:0]      last_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      owner;
    logic [1:0]      pick;
    logic            accept;
    logic            cnt_hit;
    logic            burst_end;
    logic [WIDTH-1:0] mux_y;

    mux3ne1 #(.WIDTH(WIDTH)) u_mux (
        .Hyrja0 (Hyrja0),
        .Hyrja1 (Hyrja1),
        .Hyrja2 (Hyrja2),
        .S      (S),
        .y      (mux_y)
    );

    // S only ever carries 000/001/010, so its low bits name the owner.
    assign owner = S[1:0];
    assign pick  = rr_pick(last_q, Kerkesa);

    // A beat may enter the output register when it is empty or draining now.
    assign accept = (state_q == ST_BUSY) && Kerkesa[owner] && (!DaljaValid || Gati);
    assign Pranim = accept ? (3'b001 << owner) : 3'b000;

    // Compare one bit wider so cnt_q+1 cannot wrap before matching.
    assign cnt_hit = (MAX_BURST != 0) &&
                     (({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) == (CW+1)'(MAX_BURST));

    // Dropping the owner's request ends the grant without a beat.
    assign burst_end = (accept && (Fundi[owner] || cnt_hit)) || !Kerkesa[owner];

    assign Zene = (state_q == ST_BUSY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|Kerkesa) state_d = ST_BUSY;
            ST_BUSY: if (burst_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            S       <= SEL_H0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                // S is only rewritten when a new grant starts, so the bus
                // keeps the previous owner's select through IDLE.
                if (|Kerkesa) begin
                    S     <= {1'b0, pick};
                    cnt_q <= '0;
                end
            end else begin
                if (accept && (cnt_q != {CW{1'b1}}))
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (burst_end)
                    last_q <= owner;
            end
        end
    end

    // Output register drains on Gati in any state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Dalja      <= '0;
            DaljaValid <= 1'b0;
        end else if (accept) begin
            Dalja      <= mux_y;
            DaljaValid <= 1'b1;
        end else if (Gati) begin
            DaljaValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux3ne1_arbiter.sv
module tb_mux3ne1_arbiter;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [2:0]  Kerkesa = 3'b111;
    logic [2:0]  Fundi = 3'b000;
    logic [15:0] Hyrja0 = 16'd5;
    logic [15:0] Hyrja1 = 16'd20;
    logic [15:0] Hyrja2 = 16'd23;
    logic [2:0]  Pranim;
    logic [2:0]  S;
    logic [15:0] Dalja;
    logic        DaljaValid;
    logic        Gati = 1'b1;
    logic        Zene;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mux3ne1_arbiter #(.WIDTH(16), .MAX_BURST(8)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Kerkesa    (Kerkesa),
        .Fundi      (Fundi),
        .Hyrja0     (Hyrja0),
        .Hyrja1     (Hyrja1),
        .Hyrja2     (Hyrja2),
        .Pranim     (Pranim),
        .S          (S),
        .Dalja      (Dalja),
        .DaljaValid (DaljaValid),
        .Gati       (Gati),
        .Zene       (Zene)
    );

    typedef struct {
        logic        rstn;
        logic [2:0]  k;
        logic [2:0]  f;
        logic        g;
        logic [2:0]  s;
        logic [2:0]  p;
        logic [15:0] d;
        logic        dv;
        logic        z;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rstn, input logic [2:0] k, input logic [2:0] f, input logic g,
                       input logic [2:0] s, input logic [2:0] p, input logic [15:0] d,
                       input logic dv, input logic z);
        vec_t v;
        v.rstn = rstn; v.k = k; v.f = f; v.g = g;
        v.s = s; v.p = p; v.d = d; v.dv = dv; v.z = z;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    initial begin
        int delivered;
        int cyc;
        logic [15:0] nxt;
        logic [15:0] exp_q[$];
        logic [15:0] e;

        // rstn  K      F      G     S      P      D   DV Z
        // reset held with all requesting
        add(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 0,  0, 0);
        add(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 0,  0, 0);
        // round robin 5,20,23,5 with one bubble between grants
        add(1, 3'b111, 3'b111, 1, 3'b000, 3'b000, 0,  0, 0);
        add(1, 3'b111, 3'b111, 1, 3'b000, 3'b001, 0,  0, 1);
        add(1, 3'b111, 3'b111, 1, 3'b000, 3'b000, 5,  1, 0);
        add(1, 3'b111, 3'b111, 1, 3'b001, 3'b010, 5,  0, 1);
        add(1, 3'b111, 3'b111, 1, 3'b001, 3'b000, 20, 1, 0);
        add(1, 3'b111, 3'b111, 1, 3'b010, 3'b100, 20, 0, 1);
        add(1, 3'b111, 3'b111, 1, 3'b010, 3'b000, 23, 1, 0);
        add(1, 3'b111, 3'b111, 1, 3'b000, 3'b001, 23, 0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 5,  1, 0);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 5,  0, 0);
        // single beat from requester 1
        add(1, 3'b010, 3'b010, 1, 3'b000, 3'b000, 5,  0, 0);
        add(1, 3'b010, 3'b010, 1, 3'b001, 3'b010, 5,  0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b001, 3'b000, 20, 1, 0);
        add(1, 3'b000, 3'b000, 1, 3'b001, 3'b000, 20, 0, 0);
        // backpressure on owner 2
        add(1, 3'b100, 3'b000, 1, 3'b001, 3'b000, 20, 0, 0);
        add(1, 3'b100, 3'b000, 1, 3'b010, 3'b100, 20, 0, 1);
        add(1, 3'b100, 3'b000, 0, 3'b010, 3'b000, 23, 1, 1);
        add(1, 3'b100, 3'b000, 0, 3'b010, 3'b000, 23, 1, 1);
        add(1, 3'b100, 3'b000, 0, 3'b010, 3'b000, 23, 1, 1);
        add(1, 3'b100, 3'b000, 1, 3'b010, 3'b100, 23, 1, 1);
        add(1, 3'b100, 3'b100, 1, 3'b010, 3'b100, 23, 1, 1);
        add(1, 3'b000, 3'b000, 1, 3'b010, 3'b000, 23, 1, 0);
        add(1, 3'b000, 3'b000, 1, 3'b010, 3'b000, 23, 0, 0);
        // MAX_BURST: requester 0 never ends, 8 beats then grant to 1
        add(1, 3'b011, 3'b000, 1, 3'b010, 3'b000, 23, 0, 0);
        add(1, 3'b011, 3'b000, 1, 3'b000, 3'b001, 23, 0, 1);
        for (int i = 0; i < 7; i++)
            add(1, 3'b011, 3'b000, 1, 3'b000, 3'b001, 5, 1, 1);
        add(1, 3'b011, 3'b000, 1, 3'b000, 3'b000, 5,  1, 0);
        add(1, 3'b011, 3'b000, 1, 3'b001, 3'b010, 5,  0, 1);
        // abort: owner 1 drops request mid-burst
        add(1, 3'b000, 3'b000, 1, 3'b001, 3'b000, 20, 1, 1);
        add(1, 3'b000, 3'b000, 1, 3'b001, 3'b000, 20, 0, 0);
        // reset pulsed mid-burst of owner 2
        add(1, 3'b100, 3'b000, 1, 3'b001, 3'b000, 20, 0, 0);
        add(1, 3'b100, 3'b000, 1, 3'b010, 3'b100, 20, 0, 1);
        add(1, 3'b100, 3'b000, 1, 3'b010, 3'b100, 23, 1, 1);
        add(0, 3'b100, 3'b000, 1, 3'b000, 3'b000, 0,  0, 0);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 0,  0, 0);
        // pointer back at 2: 0 not requesting, so 1 wins over 2
        add(1, 3'b110, 3'b110, 1, 3'b000, 3'b000, 0,  0, 0);
        add(1, 3'b110, 3'b110, 1, 3'b001, 3'b010, 0,  0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b001, 3'b000, 20, 1, 0);

        foreach (tv[i]) begin
            if (i != 0) begin
                @(posedge Clock);
                #1;
            end
            Resetn  = tv[i].rstn;
            Kerkesa = tv[i].k;
            Fundi   = tv[i].f;
            Gati    = tv[i].g;
            @(negedge Clock);
            chk("S",          i, 32'(S),          32'(tv[i].s));
            chk("Pranim",     i, 32'(Pranim),     32'(tv[i].p));
            chk("Dalja",      i, 32'(Dalja),      32'(tv[i].d));
            chk("DaljaValid", i, 32'(DaljaValid), 32'(tv[i].dv));
            chk("Zene",       i, 32'(Zene),       32'(tv[i].z));
        end

        // Streaming with changing data and random stalls: every accepted beat
        // must leave exactly once, in order.
        nxt = 16'd100;
        delivered = 0;
        Fundi = 3'b000;
        for (cyc = 0; cyc < 90; cyc++) begin
            @(posedge Clock);
            #1;
            Kerkesa = (cyc < 70) ? 3'b001 : 3'b000;
            Hyrja0  = nxt;
            Gati    = (cyc < 70) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge Clock);
            if (DaljaValid && Gati) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", cyc, 32'(Dalja), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", cyc, 32'(Dalja), 32'(e));
                    delivered++;
                end
            end
            if (Pranim[0]) begin
                exp_q.push_back(Hyrja0);
                nxt = nxt + 16'd1;
            end
        end
        chk("stream_left", 0, 32'(exp_q.size()), 32'd0);
        checks++;
        if (delivered < 10) begin
            errors++;
            $display("FAIL stream_count: got %0d expected at least 10", delivered);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
